// File: rtl/led_pattern_engine_if.sv
// -----------------------------------------------------------------------------
// led_pattern_engine_if
//
// Purpose: groups the control inputs and LED outputs of led_pattern_engine so
// that the board-side controller (debounce/synchroniser) and the engine share
// one bundle.
//
// Signals:
//   ena        controller -> engine  module enable; low freezes the engine
//   pat_sel    controller -> engine  requested pattern (3 bits)
//   speed_sel  controller -> engine  frame divider select (/1,/2,/4,/8)
//   pause      controller -> engine  hold the current frame
//   step       controller -> engine  single-cycle pulse, one frame while paused
//   dir        controller -> engine  marquee direction, 0 = left, 1 = right
//   bright     controller -> engine  PWM brightness (only with LED_PATTERN_DIM_EN)
//   led_out    engine -> controller  registered LED drive
//   frame_tick engine -> controller  1-cycle pulse after each frame advance
//   active_pat engine -> controller  currently displayed pattern (debug view)
//
// Signalling contract: there is no valid/ready pair here. Every control input
// is a level sampled on each rising clk edge; step is a level that counts once
// per clock it is high, so the controller must present it for exactly one
// cycle per wanted step. frame_tick is high for exactly one cycle per frame
// advance and needs no acknowledge.
//
// Optional macro: LED_PATTERN_DIM_EN adds the bright signal.
// -----------------------------------------------------------------------------
interface led_pattern_engine_if #(
    parameter int LED_W = 8
);
    logic             ena;
    logic [2:0]       pat_sel;
    logic [1:0]       speed_sel;
    logic             pause;
    logic             step;
    logic             dir;
`ifdef LED_PATTERN_DIM_EN
    logic [3:0]       bright;
`endif
    logic [LED_W-1:0] led_out;
    logic             frame_tick;
    logic [2:0]       active_pat;

`ifdef LED_PATTERN_DIM_EN
    modport master (
        output ena, pat_sel, speed_sel, pause, step, dir, bright,
        input  led_out, frame_tick, active_pat
    );
    modport slave (
        input  ena, pat_sel, speed_sel, pause, step, dir, bright,
        output led_out, frame_tick, active_pat
    );
`else
    modport master (
        output ena, pat_sel, speed_sel, pause, step, dir,
        input  led_out, frame_tick, active_pat
    );
    modport slave (
        input  ena, pat_sel, speed_sel, pause, step, dir,
        output led_out, frame_tick, active_pat
    );
`endif
endinterface

// File: rtl/led_pattern_engine.sv
// -----------------------------------------------------------------------------
// led_pattern_engine
//
// Purpose: drives LED_W LEDs with one of eight animations. A prescaler makes a
// base tick every PRESCALE clocks, a speed counter divides that by 1/2/4/8 to
// get frame advances, and the pattern state machine computes the next frame
// on each advance. Everything runs on clk using clock enables.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    led_pattern_engine_if.slave: ena, pat_sel, speed_sel, pause, step,
//          dir (and bright) in; led_out, frame_tick, active_pat out
//
// Parameters:
//   LED_W      number of LEDs, even, 4..16 (must match the interface LED_W)
//   PRESCALE   clk cycles per base tick, >= 1
//   LFSR_SEED  nonzero seed for the sparkle LFSR
//
// Optional macro: LED_PATTERN_DIM_EN adds a free-running 4-bit PWM counter and
// gates the frame with bus.bright through one extra output register.
// -----------------------------------------------------------------------------
module led_pattern_engine #(
    parameter int          LED_W     = 8,
    parameter int          PRESCALE  = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    led_pattern_engine_if.slave  bus
);

    localparam int H    = LED_W / 2;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    typedef enum logic [2:0] {
        PAT_BOUNCE  = 3'd0,
        PAT_WALK    = 3'd1,
        PAT_EXPAND  = 3'd2,
        PAT_BLINK   = 3'd3,
        PAT_ALT     = 3'd4,
        PAT_MARQUEE = 3'd5,
        PAT_SPARKLE = 3'd6,
        PAT_OFF     = 3'd7
    } pat_e;

    // State
    pat_e             active;
    logic [PS_W-1:0]  cnt;
    logic [2:0]       spd;
    logic [4:0]       ph;        // frame index within the periodic patterns
    logic [LED_W-1:0] frame;
    logic [15:0]      lfsr;
    logic             frame_tick_r;

    // Advance decode
    logic             ps_wrap;
    logic             base;
    logic             fadv;
    logic             adv;
    logic [2:0]       spd_lim;

    // Next-frame computation
    pat_e             next_pat;
    logic             sw;
    logic [4:0]       ph_nxt;
    logic [LED_W-1:0] frame_nxt;
    logic [15:0]      lfsr_nxt;
    int               per;
    int               k;
    int               e;

    always_comb begin
        spd_lim = 3'd0;
        case (bus.speed_sel)
            2'd0:    spd_lim = 3'd0;
            2'd1:    spd_lim = 3'd1;
            2'd2:    spd_lim = 3'd3;
            default: spd_lim = 3'd7;
        endcase
    end

    assign ps_wrap = (cnt == PS_MAX);
    assign base    = bus.ena & ~bus.pause & ps_wrap;
    assign fadv    = base & (spd == spd_lim);
    assign adv     = fadv | (bus.ena & bus.pause & bus.step);

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_comb begin
        next_pat  = pat_e'(bus.pat_sel);
        sw        = (next_pat != active);
        per       = 1;
        k         = 0;
        e         = 0;
        frame_nxt = '0;

        // Period of the pattern currently running; only used when not switching.
        case (active)
            PAT_BOUNCE: per = 2 * (H - 1);
            PAT_WALK:   per = 2 * (LED_W - 2);
            PAT_EXPAND: per = 2 * H;
            PAT_BLINK:  per = 2;
            PAT_ALT:    per = 2;
            default:    per = 1;
        endcase

        // A switch restarts the new pattern at its first frame.
        if (sw || (int'(ph) >= per - 1))
            ph_nxt = 5'd0;
        else
            ph_nxt = ph + 5'd1;

        k = int'(ph_nxt);

        case (next_pat)
            PAT_BOUNCE: begin
                // Ping-pong with end frames shown once: 0..H-1..1.
                if (k >= H)
                    k = 2 * (H - 1) - k;
                for (int i = 0; i < LED_W; i++)
                    frame_nxt[i] = (i == k) || (i == LED_W - 1 - k);
            end
            PAT_WALK: begin
                if (k > LED_W - 2)
                    k = 2 * (LED_W - 2) - k;
                for (int i = 0; i < LED_W; i++)
                    frame_nxt[i] = (i == k) || (i == k + 1);
            end
            PAT_EXPAND: begin
                // e = 1..H, H-1..1, then 0 which leaves the band empty.
                if (k < H)
                    e = k + 1;
                else
                    e = 2 * H - 1 - k;
                for (int i = 0; i < LED_W; i++)
                    frame_nxt[i] = (i >= H - e) && (i <= H + e - 1);
            end
            PAT_BLINK: begin
                frame_nxt = (k == 0) ? '1 : '0;
            end
            PAT_ALT: begin
                for (int i = 0; i < LED_W; i++)
                    frame_nxt[i] = ((i % 2) == 0) ^ (k == 1);
            end
            PAT_MARQUEE: begin
                // The marquee state is the displayed frame itself.
                if (sw) begin
                    frame_nxt      = '0;
                    frame_nxt[2:0] = 3'b111;
                end else if (bus.dir) begin
                    frame_nxt = {frame[0], frame[LED_W-1:1]};
                end else begin
                    frame_nxt = {frame[LED_W-2:0], frame[LED_W-1]};
                end
            end
            PAT_SPARKLE: begin
                // Show the current value; the shift happens on the same edge.
                frame_nxt = lfsr[LED_W-1:0];
            end
            default: begin
                frame_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active       <= PAT_OFF;
            cnt          <= '0;
            spd          <= 3'd0;
            ph           <= 5'd0;
            frame        <= '0;
            lfsr         <= LFSR_SEED;
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= adv;

            if (bus.ena && !bus.pause)
                cnt <= ps_wrap ? '0 : cnt + PS_W'(1);

            // Reaching the limit advances; overshooting after a speed_sel
            // decrease just clears without advancing.
            if (base)
                spd <= (spd >= spd_lim) ? 3'd0 : spd + 3'd1;

            if (adv) begin
                active <= next_pat;
                ph     <= ph_nxt;
                frame  <= frame_nxt;
                if (next_pat == PAT_SPARKLE)
                    lfsr <= lfsr_nxt;
            end
        end
    end

    assign bus.frame_tick = frame_tick_r;
    assign bus.active_pat = active;

`ifdef LED_PATTERN_DIM_EN
    logic [3:0]       pwm;
    logic [LED_W-1:0] led_q;

    // PWM runs independently of ena/pause so dimming never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm   <= 4'd0;
            led_q <= '0;
        end else begin
            pwm   <= pwm + 4'd1;
            led_q <= frame & {LED_W{(bus.bright == 4'd15) | (pwm < bus.bright)}};
        end
    end

    assign bus.led_out = led_q;
`else
    assign bus.led_out = frame;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_engine
//
// Directed bench for led_pattern_engine with LED_W=8, PRESCALE=1. Expected
// frames are hand-computed constants; sequences are queued in exp_q and popped
// as frame_tick pulses arrive. With LED_PATTERN_DIM_EN defined the brightness
// gating is exercised instead of the animation sequences.
// -----------------------------------------------------------------------------
module tb_led_pattern_engine;

    localparam int LED_W = 8;

    logic clk = 1'b0;
    logic rst_n;

    led_pattern_engine_if #(.LED_W(LED_W)) bus ();

    led_pattern_engine #(
        .LED_W     (LED_W),
        .PRESCALE  (1),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    int          tick_total = 0;
    logic [15:0] exp_q[$];

    always @(negedge clk) begin
        if (bus.frame_tick === 1'b1)
            tick_total++;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Waits for the next frame_tick (at least one clock), reports clocks used.
    task automatic wait_frame(input string tag, output int cycles);
        cycles = 1;
        @(negedge clk);
        while (bus.frame_tick !== 1'b1 && cycles < 64) begin
            @(negedge clk);
            cycles++;
        end
        check_eq({tag, "_tick"}, {15'd0, bus.frame_tick}, 16'd1);
    endtask

    // Pops exp_q, one frame per tick; frames must arrive on consecutive clocks.
    task automatic check_frames(input string tag);
        int c;
        while (exp_q.size() > 0) begin
            wait_frame(tag, c);
            check_eq({tag, "_gap"}, 16'(c), 16'd1);
            check_eq(tag, 16'(bus.led_out), exp_q.pop_front());
        end
    endtask

    // n clocks with led_out fixed and no tick; optional step pulse at step_at.
    task automatic run_hold(input int n, input logic [15:0] exp, input int step_at,
                            input string tag);
        int bad = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (16'(bus.led_out) !== exp || bus.frame_tick !== 1'b0)
                bad++;
            bus.step = (i == step_at);
        end
        bus.step = 1'b0;
        check_eq(tag, 16'(bad), 16'd0);
    endtask

    // Watchdog: never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int c;
        int t0;
        int r;

        rst_n         = 1'b0;
        bus.ena       = 1'b0;
        bus.pat_sel   = 3'd0;
        bus.speed_sel = 2'd0;
        bus.pause     = 1'b0;
        bus.step      = 1'b0;
        bus.dir       = 1'b0;
`ifdef LED_PATTERN_DIM_EN
        bus.bright    = 4'd15;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_led", 16'(bus.led_out), 16'h00);
        check_eq("rst_tick", {15'd0, bus.frame_tick}, 16'd0);
        check_eq("rst_pat", 16'(bus.active_pat), 16'd7);
        rst_n = 1'b1;
        @(negedge clk);
        bus.ena = 1'b1;

`ifdef LED_PATTERN_DIM_EN
        // Blink on-frame held by pause, then observe brightness gating.
        bus.pat_sel = 3'd3;
        wait_frame("dim_first", c);
        bus.pause = 1'b1;
        for (int b = 0; b < 3; b++) begin
            int on_cnt = 0;
            int bad    = 0;
            logic [3:0] bv;
            int exp_on;
            bv     = (b == 0) ? 4'd4 : (b == 1) ? 4'd15 : 4'd0;
            exp_on = (b == 0) ? 4 : (b == 1) ? 16 : 0;
            bus.bright = bv;
            repeat (2) @(negedge clk);
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (bus.led_out === 8'hFF) on_cnt++;
                else if (bus.led_out !== 8'h00) bad++;
            end
            check_eq("dim_on_count", 16'(on_cnt), 16'(exp_on));
            check_eq("dim_other", 16'(bad), 16'd0);
        end
`else
        // 1: bounce at full speed.
        exp_q = '{16'h81, 16'h42, 16'h24, 16'h18, 16'h24, 16'h42, 16'h81, 16'h42};
        check_frames("bounce");

        // 2: marquee, left then right.
        bus.pat_sel = 3'd5;
        exp_q = '{16'h07, 16'h0E, 16'h1C};
        check_frames("marq_left");
        bus.dir = 1'b1;
        exp_q = '{16'h0E, 16'h07, 16'h83};
        check_frames("marq_right");

        // 3: blink at /8.
        bus.pat_sel   = 3'd3;
        bus.speed_sel = 2'd3;
        wait_frame("blink_on", c);
        check_eq("blink_first_gap", 16'(c), 16'd8);
        check_eq("blink_on", 16'(bus.led_out), 16'hFF);
        run_hold(7, 16'hFF, 0, "blink_on_hold");
        wait_frame("blink_off", c);
        check_eq("blink_off", 16'(bus.led_out), 16'h00);
        run_hold(7, 16'h00, 0, "blink_off_hold");
        wait_frame("blink_on2", c);
        check_eq("blink_on2", 16'(bus.led_out), 16'hFF);

        // 4: expand, pause and single-step.
        bus.pat_sel   = 3'd2;
        bus.speed_sel = 2'd0;
        exp_q = '{16'h18, 16'h3C};
        check_frames("expand");
        bus.pause = 1'b1;
        run_hold(5, 16'h3C, 0, "pause_hold");
        t0 = tick_total;
        exp_q = '{16'h7E, 16'hFF, 16'h7E};
        while (exp_q.size() > 0) begin
            logic [15:0] ev;
            ev = exp_q.pop_front();
            bus.step = 1'b1;
            wait_frame("step", c);
            bus.step = 1'b0;
            check_eq("step_gap", 16'(c), 16'd1);
            check_eq("step_led", 16'(bus.led_out), ev);
            run_hold(4, ev, 0, "step_hold");
        end
        check_eq("step_ticks", 16'(tick_total - t0), 16'd3);
        // step while running must not add a frame.
        bus.pause     = 1'b0;
        bus.speed_sel = 2'd3;
        r = $urandom_range(1, 5);
        run_hold(7, 16'h7E, r, "step_unpaused");
        wait_frame("resume", c);
        check_eq("resume_led", 16'(bus.led_out), 16'h3C);

        // 5: walking pair, switch to alternate between ticks, then ena=0.
        bus.pat_sel = 3'd1;
        run_hold(7, 16'h3C, 0, "walk_wait");
        wait_frame("walk0", c);
        check_eq("walk0", 16'(bus.led_out), 16'h03);
        run_hold(7, 16'h03, 0, "walk_hold");
        wait_frame("walk1", c);
        check_eq("walk1", 16'(bus.led_out), 16'h06);
        bus.pat_sel = 3'd4;
        run_hold(7, 16'h06, 0, "switch_hold");
        wait_frame("alt0", c);
        check_eq("alt0", 16'(bus.led_out), 16'h55);
        run_hold(7, 16'h55, 0, "alt_hold");
        wait_frame("alt1", c);
        check_eq("alt1", 16'(bus.led_out), 16'hAA);
        bus.ena     = 1'b0;
        bus.pat_sel = 3'd0;
        run_hold(20, 16'hAA, 0, "ena_freeze");
        check_eq("ena_pat", 16'(bus.active_pat), 16'd4);
        bus.ena = 1'b1;
        run_hold(7, 16'hAA, 0, "reenable_hold");
        wait_frame("reenable", c);
        check_eq("reenable_led", 16'(bus.led_out), 16'h81);
        check_eq("reenable_pat", 16'(bus.active_pat), 16'd0);

        // Asynchronous reset mid-animation, then sparkle from the seed.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_led", 16'(bus.led_out), 16'h00);
        check_eq("async_rst_pat", 16'(bus.active_pat), 16'd7);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.pat_sel   = 3'd6;
        bus.speed_sel = 2'd0;
        exp_q = '{16'hE1, 16'hC3, 16'h87};
        check_frames("sparkle");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Parametrised successor to the fixed 8-LED pattern generator: drives LED_W LEDs with eight selectable animations.
- Uses a single clock domain with clock-enable frame ticks; there is no derived clock.
- Adds programmable prescale, a 4-step speed select, single-step while paused, marquee direction control and glitch-free pattern switching on frame boundaries.
- Sits between the board input synchroniser/debounce and the LED pads.

Parameters:
- LED_W, 8, number of LEDs; even; range 4..16.
- PRESCALE, 1, clk cycles per base tick; >=1.
- LFSR_SEED, 16'hACE1, nonzero 16-bit sparkle seed.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ena  in  1  module enable; low freezes everything, including step.
- pat_sel  in  3  requested pattern.
- speed_sel  in  2  frame divider: 0,1,2,3 select /1,/2,/4,/8 of base tick.
- pause  in  1  high holds the current frame.
- step  in  1  1-cycle pulse; advances one frame while paused.
- dir  in  1  marquee direction: 0 = rotate left, 1 = rotate right.
- led_out  out  LED_W  registered LED drive.
- frame_tick  out  1  registered 1-cycle pulse, high the cycle after each frame advance.

Behaviour:
- Reset values:
  - led_out 0, frame_tick 0.
  - Active pattern 3'b111.
  - Prescaler, speed counter and all pattern state 0.
  - LFSR = LFSR_SEED.
- Prescaler:
  - Counts 0..PRESCALE-1 only while ena=1 and pause=0.
  - base = ena & ~pause & (cnt == PRESCALE-1).
- Speed counter:
  - 3-bit; increments on base.
  - fadv = base & (spd == (1<<speed_sel)-1), then spd clears.
  - A speed_sel change takes effect on the next base; if spd already exceeds the new limit, spd clears on the next base without advancing.
- Frame advance: adv = fadv | (ena & pause & step). step is ignored when pause=0 or ena=0.
- On the edge where adv=1:
  - led_out takes the new frame.
  - frame_tick=1 on the following cycle.
  - Latency is exactly 1 clk from adv.
  - Prescaler and speed counter hold while pause=1 and resume from their held values.
- Pattern switch:
  - pat_sel is sampled only on adv.
  - If it differs from the active pattern, that pattern's state is cleared and led_out shows its first frame on that same edge.
  - The LFSR is never cleared by a pattern switch.
- H = LED_W/2. Patterns (first frame listed first):
  - 0 bounce: k=0..H-1..0 ping-pong, end frames shown once; led = bit k | bit LED_W-1-k; period 2(H-1).
  - 1 walking pair: p=0..LED_W-2..0 ping-pong, end frames shown once; led = bits p,p+1; period 2(LED_W-2).
  - 2 expand: e=1..H then H-1..1 then all-off frame; led = bits H-e..H+e-1; period 2H.
  - 3 blink: all-on, all-off alternating.
  - 4 alternate: even-indexed bits set (0x55 for 8), then inverse, alternating.
  - 5 marquee: starts with low 3 bits set; each later frame rotates by one per dir, sampled at each adv.
  - 6 sparkle:
    - 16-bit Fibonacci LFSR with taps 16,14,13,11; led = lfsr[LED_W-1:0].
    - The shift occurs after the value is displayed, so the first frame shows the current LFSR value.
  - 7 off: all zero.
- ena=0:
  - All registers hold.
  - pat_sel changes are ignored until the next adv after re-enable.
- Reset mid-animation returns all state to reset values immediately (asynchronous).

Optional Feature:
- Macro LED_PATTERN_DIM_EN.
- When defined:
  - Adds input bright[3:0] and a free-running 4-bit PWM counter. The counter runs regardless of ena/pause and resets to 0.
  - led_out = frame & {LED_W{bright==15 | pwm<bright}}; bright=0 gives dark.
  - frame is the internal registered pattern; the gated output is registered once more, adding 1 clk latency.
- When undefined: no bright port, no PWM counter; led_out = frame with 1-clk latency.

Test Plan:
1. Reset, ena=1, pat_sel=0, speed 0, PRESCALE=1, LED_W=8 -> successive led_out 0x81, 0x42, 0x24, 0x18, 0x24, 0x42, 0x81, 0x42.
2. pat_sel=5, dir=0, then dir=1 after 3 frames -> led_out 0x07, 0x0E, 0x1C, 0x0E, 0x07, 0x83.
3. pat_sel=3, speed_sel=3 -> led_out 0xFF held for 8 clk, then 0x00 for 8 clk; frame_tick pulses every 8 clk.
4. pat_sel=2, pause=1 mid-run, then three step pulses spaced 5 clk apart -> exactly three advances; no change in between; frame_tick count = 3; step with pause=0 has no effect.
5. Running pattern 1, change pat_sel to 4 between ticks -> led_out unchanged until next adv, then 0x55, then 0xAA; ena=0 for 20 clk freezes led_out and frame_tick.
6. LED_PATTERN_DIM_EN defined, pattern 3 on-frame, bright=4 -> led_out 0xFF for 4 of every 16 clk; bright=15 -> constant 0xFF; bright=0 -> 0x00.
